// File: rtl/alu_issuer_if.sv
// Request/response handshake plus ALU port bundle for alu_issuer.
// slave = issuer side, master = controller / ALU side.
interface alu_issuer_if;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
  logic [3:0]  req_cmd;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_y;
  logic        rsp_err;

  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_command;
  logic        alu_oe;
  logic [15:0] alu_y;

  logic [15:0] op_count;

  modport slave (
    input  req_valid, req_a, req_b, req_cmd, rsp_ready, alu_y,
    output req_ready, rsp_valid, rsp_y, rsp_err,
           alu_a, alu_b, alu_command, alu_oe, op_count
  );

  modport master (
    output req_valid, req_a, req_b, req_cmd, rsp_ready, alu_y,
    input  req_ready, rsp_valid, rsp_y, rsp_err,
           alu_a, alu_b, alu_command, alu_oe, op_count
  );
endinterface

// File: rtl/alu_issuer.sv
// Valid/ready front-end that runs one combinational ALU operation per request.
// Optional: ALU_ISSUER_DIVZERO_CHK_EN short-circuits DIV by zero to an error response.
module alu_issuer #(
  parameter int unsigned SETTLE_CYCLES = 1  // legal 1..15
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_issuer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, PRIME, EXEC, RESP} state_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] cmd;
  } req_t;

  localparam logic [3:0] CMD_DIV     = 4'h5;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      st, st_nxt;
  req_t        op_q;
  logic [3:0]  settle_q;
  logic [15:0] y_q;
  logic [15:0] cnt_q;
  logic        accept, divzero, settle_done, rsp_hs;

  assign accept      = (st == IDLE) && bus.req_valid;
  assign settle_done = (st == EXEC) && (settle_q == SETTLE_LAST);
  assign rsp_hs      = (st == RESP) && bus.rsp_ready;

`ifdef ALU_ISSUER_DIVZERO_CHK_EN
  assign divzero = (bus.req_cmd == CMD_DIV) && (bus.req_b == 8'h00);
`else
  assign divzero = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nxt;
  end

  // Command is flipped in PRIME so EXEC always presents a fresh command edge.
  always_comb begin
    st_nxt          = st;
    bus.req_ready   = 1'b0;
    bus.rsp_valid   = 1'b0;
    bus.alu_oe      = 1'b0;
    bus.alu_command = op_q.cmd;
    unique case (st)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) st_nxt = divzero ? RESP : PRIME;
      end
      PRIME: begin
        bus.alu_command = op_q.cmd ^ 4'b0001;
        st_nxt          = EXEC;
      end
      EXEC: begin
        bus.alu_oe = 1'b1;
        if (settle_done) st_nxt = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  // A short-circuited request leaves the ALU operand registers untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      settle_q <= '0;
      y_q      <= '0;
      cnt_q    <= '0;
    end else begin
      if (accept && !divzero) op_q <= '{a: bus.req_a, b: bus.req_b, cmd: bus.req_cmd};
      settle_q <= ((st == EXEC) && !settle_done) ? settle_q + 4'd1 : 4'd0;
      if (settle_done)        y_q   <= bus.alu_y;
      if (accept && divzero)  y_q   <= 16'hFFFF;
      if (rsp_hs)             cnt_q <= cnt_q + 16'd1;
    end
  end

`ifdef ALU_ISSUER_DIVZERO_CHK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                err_q <= 1'b0;
    else if (accept && divzero) err_q <= 1'b1;
    else if (settle_done)      err_q <= 1'b0;
  end
  assign bus.rsp_err = err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.alu_a    = op_q.a;
  assign bus.alu_b    = op_q.b;
  assign bus.rsp_y    = y_q;
  assign bus.op_count = cnt_q;
endmodule

// File: tb/tb_alu_issuer.sv
// Directed bench for alu_issuer: two instances (SETTLE_CYCLES 1 and 4) behind a
// behavioural ALU that only re-evaluates when alu_command changes.
module tb_alu_issuer;
`ifdef ALU_ISSUER_DIVZERO_CHK_EN
  localparam bit DZ = 1'b1;
`else
  localparam bit DZ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issuer_if bus1();
  alu_issuer_if bus4();

  alu_issuer #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  alu_issuer #(.SETTLE_CYCLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  // ALU model: 0 ADD, 1 SUB, 2 MUL, 5 DIV, F BUF; anything else 5A5A.
  function automatic logic [15:0] alu_f(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    case (c)
      4'h0:    alu_f = {8'h0, a} + {8'h0, b};
      4'h1:    alu_f = {8'h0, a} - {8'h0, b};
      4'h2:    alu_f = {8'h0, a} * {8'h0, b};
      4'h5:    alu_f = (b == 8'h0) ? 16'h0BAD : {8'h0, a / b};
      4'hF:    alu_f = {8'h0, a};
      default: alu_f = 16'h5A5A;
    endcase
  endfunction

  logic [15:0] res1 = 16'h0;
  logic [15:0] res4 = 16'h0;
  always @(bus1.alu_command) res1 = alu_f(bus1.alu_command, bus1.alu_a, bus1.alu_b);
  always @(bus4.alu_command) res4 = alu_f(bus4.alu_command, bus4.alu_a, bus4.alu_b);
  // DEAD when disabled, so a sample outside EXEC is visible.
  assign bus1.alu_y = bus1.alu_oe ? res1 : 16'hDEAD;
  assign bus4.alu_y = bus4.alu_oe ? res4 : 16'hDEAD;

  // Shared request drivers; sel steers req_valid and the observed outputs.
  logic       sel = 1'b0, rv = 1'b0, rr = 1'b0;
  logic [7:0] ra = 8'h0, rb = 8'h0;
  logic [3:0] rc = 4'h0;
  assign bus1.req_valid = rv & ~sel;
  assign bus4.req_valid = rv & sel;
  assign bus1.req_a = ra;  assign bus4.req_a = ra;
  assign bus1.req_b = rb;  assign bus4.req_b = rb;
  assign bus1.req_cmd = rc; assign bus4.req_cmd = rc;
  assign bus1.rsp_ready = rr; assign bus4.rsp_ready = rr;

  logic        m_req_ready, m_rsp_valid, m_err, m_oe;
  logic [15:0] m_y, m_cnt;
  logic [3:0]  m_cmd;
  assign m_req_ready = sel ? bus4.req_ready   : bus1.req_ready;
  assign m_rsp_valid = sel ? bus4.rsp_valid   : bus1.rsp_valid;
  assign m_err       = sel ? bus4.rsp_err     : bus1.rsp_err;
  assign m_oe        = sel ? bus4.alu_oe      : bus1.alu_oe;
  assign m_y         = sel ? bus4.rsp_y       : bus1.rsp_y;
  assign m_cnt       = sel ? bus4.op_count    : bus1.op_count;
  assign m_cmd       = sel ? bus4.alu_command : bus1.alu_command;

  int checks = 0;
  int failures = 0;
  int cnt1 = 0;
  int cnt4 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // idx = negedge index (1 = first after acceptance) where rsp_valid is first seen.
  task automatic run_op(input string tag, input logic s, input logic [3:0] c,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] ey, input logic ee, input int eidx,
                        input int eoe, input bit chk_prime, input int ecnt);
    int idx, oe_n;
    logic got, e;
    logic [3:0] pcmd;
    logic [15:0] y;
    @(negedge clk);
    sel = s; ra = a; rb = b; rc = c; rv = 1'b1; rr = 1'b1;
    #1 chk({tag, " req_ready"}, 32'(m_req_ready), 32'd1);
    @(posedge clk);
    #1 rv = 1'b0; ra = 8'hEE; rb = 8'hEE; rc = 4'h3;
    idx = 0; oe_n = 0; got = 1'b0; e = 1'b0; pcmd = 4'h0; y = 16'h0;
    while (!got && idx < 40) begin
      @(negedge clk);
      idx++;
      if (m_oe) oe_n++;
      if (idx == 1) pcmd = m_cmd;
      if (m_rsp_valid) begin got = 1'b1; y = m_y; e = m_err; end
    end
    chk({tag, " rsp_seen"}, 32'(got), 32'd1);
    chk({tag, " rsp_y"}, 32'(y), 32'(ey));
    chk({tag, " rsp_err"}, 32'(e), 32'(ee));
    chk({tag, " latency"}, 32'(idx), 32'(eidx));
    chk({tag, " oe_cycles"}, 32'(oe_n), 32'(eoe));
    if (chk_prime) chk({tag, " prime_cmd"}, 32'(pcmd), 32'(c ^ 4'h1));
    @(negedge clk);
    chk({tag, " idle_ready"}, 32'(m_req_ready), 32'd1);
    chk({tag, " idle_rsp_valid"}, 32'(m_rsp_valid), 32'd0);
    chk({tag, " op_count"}, 32'(m_cnt), 32'(ecnt));
  endtask

  typedef struct {
    logic [3:0]  cmd;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] y;
    logic        err;
    int          idx;
    int          oe;
    bit          prime;
  } vec_t;

  vec_t vt[10];

  initial begin
    int bad, seen;

    vt[0] = '{4'h0, 8'd200, 8'd100, 16'd300,  1'b0, 3, 1, 1'b1};
    vt[1] = '{4'hF, 8'h12,  8'h00,  16'h0012, 1'b0, 3, 1, 1'b1};
    vt[2] = '{4'hF, 8'h34,  8'h00,  16'h0034, 1'b0, 3, 1, 1'b1};
    vt[3] = '{4'h1, 8'd5,   8'd7,   16'hFFFE, 1'b0, 3, 1, 1'b1};
    vt[4] = '{4'h5, 8'd9,   8'd2,   16'd4,    1'b0, 3, 1, 1'b1};
    vt[5] = '{4'h5, 8'd9,   8'd0,   DZ ? 16'hFFFF : 16'h0BAD, DZ, DZ ? 1 : 3, DZ ? 0 : 1, !DZ};
    vt[6] = '{4'h0, 8'd1,   8'd1,   16'd2,    1'b0, 3, 1, 1'b1};
    vt[7] = '{4'h0, 8'd2,   8'd3,   16'd5,    1'b0, 3, 1, 1'b1};
    vt[8] = '{4'h0, 8'd255, 8'd255, 16'h01FE, 1'b0, 3, 1, 1'b1};
    vt[9] = '{4'h7, 8'd1,   8'd1,   16'h5A5A, 1'b0, 3, 1, 1'b1};

    // Reset values while rst_n is held low from time 0.
    #3;
    chk("rst req_ready", 32'(bus1.req_ready), 32'd1);
    chk("rst rsp_valid", 32'(bus1.rsp_valid), 32'd0);
    chk("rst rsp_y", 32'(bus1.rsp_y), 32'd0);
    chk("rst rsp_err", 32'(bus1.rsp_err), 32'd0);
    chk("rst alu_bus", 32'({bus1.alu_a, bus1.alu_b, bus1.alu_command, bus1.alu_oe}), 32'd0);
    chk("rst op_count", 32'(bus1.op_count), 32'd0);
    chk("rst dut4 op_count", 32'(bus4.op_count), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      cnt1++;
      run_op($sformatf("vec%0d", i), 1'b0, vt[i].cmd, vt[i].a, vt[i].b, vt[i].y,
             vt[i].err, vt[i].idx, vt[i].oe, vt[i].prime, cnt1);
    end

    // Backpressure: MUL held in RESP for 10 cycles while a new request waits.
    @(negedge clk);
    sel = 1'b0; ra = 8'd255; rb = 8'd255; rc = 4'h2; rv = 1'b1; rr = 1'b0;
    @(posedge clk);
    #1 ra = 8'd1; rb = 8'd1; rc = 4'h0;
    seen = 0;
    for (int k = 0; k < 10 && seen == 0; k++) begin
      @(negedge clk);
      if (m_rsp_valid) seen = 1;
    end
    chk("stall rsp_seen", 32'(seen), 32'd1);
    chk("stall rsp_y", 32'(m_y), 32'hFE01);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m_y !== 16'hFE01 || m_rsp_valid !== 1'b1 || m_req_ready !== 1'b0 || m_oe !== 1'b0) bad++;
    end
    chk("stall hold_cycles_bad", 32'(bad), 32'd0);
    chk("stall op_count", 32'(m_cnt), 32'(cnt1));
    rv = 1'b0; rr = 1'b1;
    @(negedge clk);
    cnt1++;
    chk("stall post req_ready", 32'(m_req_ready), 32'd1);
    chk("stall post rsp_valid", 32'(m_rsp_valid), 32'd0);
    chk("stall post op_count", 32'(m_cnt), 32'(cnt1));

    // Longer settle window.
    cnt4++;
    run_op("sub4", 1'b1, 4'h1, 8'd5, 8'd7, 16'hFFFE, 1'b0, 6, 4, 1'b1, cnt4);

    // Reset in the middle of EXEC.
    @(negedge clk);
    sel = 1'b1; ra = 8'd3; rb = 8'd4; rc = 4'h0; rv = 1'b1; rr = 1'b1;
    @(posedge clk);
    #1 rv = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst in_exec oe", 32'(m_oe), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst oe", 32'(m_oe), 32'd0);
    chk("midrst rsp_valid", 32'(m_rsp_valid), 32'd0);
    chk("midrst req_ready", 32'(m_req_ready), 32'd1);
    chk("midrst rsp_y", 32'(m_y), 32'd0);
    chk("midrst op_count", 32'(m_cnt), 32'd0);
    chk("midrst alu_bus", 32'({bus4.alu_a, bus4.alu_b, bus4.alu_command}), 32'd0);
    chk("midrst dut1 op_count", 32'(bus1.op_count), 32'd0);
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (m_rsp_valid) seen++;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (m_rsp_valid) seen++;
    end
    chk("midrst no_rsp_pulse", 32'(seen), 32'd0);
    cnt4 = 1;
    cnt1 = 1;
    run_op("post_rst4", 1'b1, 4'h0, 8'd3, 8'd4, 16'd7, 1'b0, 6, 4, 1'b1, cnt4);
    run_op("post_rst1", 1'b0, 4'hF, 8'h5C, 8'h00, 16'h005C, 1'b0, 3, 1, 1'b1, cnt1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
